vedic_seq_mult: RTL and testbench



---
 rtl/vedic_seq_mult.sv | 133 +++++++++++++
 tb/tb_vedic_seq_mult.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_mult.sv
// Iterative unsigned WIDTH x WIDTH multiplier. Each cycle, a row of 2x2 Vedic cells
// multiplies a by one 2-bit digit of b. Optional early termination: VEDIC_EARLY_TERM_EN.

module vedic_cell_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  always_comb begin
    c1   = (a[1] & b[0]) & (a[0] & b[1]);
    p[0] = a[0] & b[0];
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    p[2] = (a[1] & b[1]) ^ c1;
    p[3] = (a[1] & b[1]) & c1;
  end
endmodule

module vedic_seq_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int NUM_LANES = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                        state, state_nxt;
  logic [WIDTH-1:0]              a_q, b_q;
  logic [2*WIDTH-1:0]            acc_q, acc_nxt, row_sh, product_q;
  logic [CNT_W-1:0]              j_q;
  logic [CNT_W:0]                dig_sh;
  logic [1:0]                    b_dig;
  logic [NUM_LANES-1:0][3:0]     cell_p;
  logic [WIDTH+1:0]              row;
  logic                          accept, last_dig, finish;

  assign dig_sh = {j_q, 1'b0};
  assign b_dig  = 2'(b_q >> dig_sh);
  assign accept = in_valid && in_ready;

  // one 2x2 cell per 2-bit slice of a, all sharing the current digit of b
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vedic_cell_2x2 u_cell (
      .a (a_q[2*g +: 2]),
      .b (b_dig),
      .p (cell_p[g])
    );
  end

  always_comb begin
    row = '0;
    for (int k = 0; k < NUM_LANES; k++)
      row = row + ((WIDTH+2)'(cell_p[k]) << (2*k));
  end

  assign row_sh  = (2*WIDTH)'(row) << dig_sh;
  assign acc_nxt = acc_q + row_sh;
  assign last_dig = (j_q == CNT_W'(NUM_LANES-1));

`ifdef VEDIC_EARLY_TERM_EN
  // stop once every digit of b above the current one is zero
  logic rest_zero;
  assign rest_zero = ((b_q >> dig_sh) >> 2) == '0;
  assign finish    = last_dig || rest_zero;
`else
  assign finish    = last_dig;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (finish) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      j_q       <= '0;
      product_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        acc_q <= '0;
        j_q   <= '0;
      end else if (state == BUSY) begin
        acc_q <= acc_nxt;
        j_q   <= j_q + 1'b1;
        if (finish) product_q <= acc_nxt;
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Directed and randomized checks for vedic_seq_mult at WIDTH=32.
module tb_vedic_seq_mult;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;

  vedic_seq_mult #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [31:0] bv);
    int l;
    l = 16;
`ifdef VEDIC_EARLY_TERM_EN
    l = 1;
    for (int d = 0; d < 16; d++)
      if (bv[2*d +: 2] != 2'b00) l = d + 1;
`endif
    return l;
  endfunction

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // counts edges from accept until out_valid, bounded
  task automatic wait_valid(output int lat, output int bc, output bit tmo);
    lat = 0; bc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    tmo = !out_valid;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (product !== 64'h0) $display("FAIL reset_product got=%h exp=0", product); else pass_cnt++;
  endtask

  task automatic test_max();
    int lat, bc; bit tmo;
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat, bc, tmo);
    total++; if (tmo) $display("FAIL max_timeout out_valid never rose"); else pass_cnt++;
    total++; if (product !== 64'hFFFFFFFE00000001) $display("FAIL max_product got=%h exp=fffffffe00000001", product); else pass_cnt++;
    total++; if (lat != 16) $display("FAIL max_latency got=%0d exp=16", lat); else pass_cnt++;
    total++; if (bc != 16) $display("FAIL max_busy_cycles got=%0d exp=16", bc); else pass_cnt++;
    consume();
  endtask

  task automatic test_zero_identity();
    int lat, bc; bit tmo;
    start_op(32'h12345678, 32'h0);
    wait_valid(lat, bc, tmo);
    total++; if (tmo || product !== 64'h0) $display("FAIL zero_product got=%h exp=0 tmo=%b", product, tmo); else pass_cnt++;
    total++; if (lat != exp_lat(32'h0)) $display("FAIL zero_latency got=%0d exp=%0d", lat, exp_lat(32'h0)); else pass_cnt++;
    consume();
    start_op(32'h12345678, 32'h1);
    wait_valid(lat, bc, tmo);
    total++; if (tmo || product !== 64'h0000000012345678) $display("FAIL ident_product got=%h exp=12345678 tmo=%b", product, tmo); else pass_cnt++;
    total++; if (lat != exp_lat(32'h1)) $display("FAIL ident_latency got=%0d exp=%0d", lat, exp_lat(32'h1)); else pass_cnt++;
    consume();
  endtask

  task automatic test_backpressure();
    int lat, bc, bad; bit tmo;
    start_op(32'd7, 32'd9);
    wait_valid(lat, bc, tmo);
    total++; if (tmo || product !== 64'd63) $display("FAIL bp_product got=%0d exp=63 tmo=%b", product, tmo); else pass_cnt++;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (product !== 64'd63 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL bp_hold bad_cycles=%0d exp=0 (product=%0d ov=%b ir=%b)", bad, product, out_valid, in_ready); else pass_cnt++;
    consume();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_ignored_input();
    int lat, bc; bit tmo;
    start_op(32'd3, 32'd4);
    @(negedge clk);
    a = 32'd5; b = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat, bc, tmo);
    total++; if (tmo || product !== 64'd12) $display("FAIL ignored_product got=%0d exp=12 tmo=%b", product, tmo); else pass_cnt++;
    consume();
    repeat (3) @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL ignored_idle ov=%b busy=%b ir=%b exp 0/0/1", out_valid, busy, in_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int stale;
    start_op(32'hFFFF0000, 32'hFFFF0000);
    repeat (7) @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got=%b exp=1", busy); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || product !== 64'h0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rstmid_outputs ov=%b prod=%h ir=%b busy=%b exp 0/0/1/0", out_valid, product, in_ready, busy);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    total++; if (stale != 0) $display("FAIL rstmid_stale cycles=%0d exp=0", stale); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, bc, accepts, outs; bit tmo;
    logic [31:0] ra, rb;
    logic [63:0] ref_p;
    accepts = 0; outs = 0;
    for (int n = 0; n < 400; n++) begin
      ra = $urandom; rb = $urandom;
      if (n % 7 == 0) rb = rb & 32'h0000_00FF;
      ref_p = 64'(ra) * 64'(rb);
      start_op(ra, rb);
      accepts++;
      wait_valid(lat, bc, tmo);
      if (!tmo) outs++;
      total++;
      if (tmo || product !== ref_p) $display("FAIL rand_product a=%h b=%h got=%h exp=%h", ra, rb, product, ref_p);
      else pass_cnt++;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      consume();
    end
    total++; if (outs != accepts) $display("FAIL rand_count products=%0d accepts=%0d", outs, accepts); else pass_cnt++;
  endtask

  initial begin
    #12 test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_max();
    test_zero_identity();
    test_backpressure();
    test_ignored_input();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
